// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// A control bundle and a data bundle travel together between two pipeline stages.
// in_ready is derived only from registered state, so a downstream stall never
// reaches upstream through a combinational path.
// A synchronous flush kills every held entry. A bubble (no valid entry) shows
// all-zero control downstream, which acts as a NOP.
module pipe_stage_skid #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 96,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // EMPTY: no entry held; BUSY: main entry only; FULL: main plus skid entry
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CNT_W-1:0]  bubble_q, bubble_d;

   logic xfer_in;
   logic xfer_out;

   // Handshake signals; every one is a function of registered state only
   always_comb begin
      in_ready  = (state_q != ST_FULL);
      out_valid = (state_q != ST_EMPTY);
      xfer_in   = in_valid & in_ready;
      xfer_out  = out_valid & out_ready;
   end

   // Entry outputs; control is masked so a bubble presents a NOP
   always_comb begin
      out_ctrl   = out_valid ? main_ctrl_q : '0;
      out_data   = main_data_q;
      bubble_cnt = bubble_q;
   end

   // Next state and entry movement; flush overrides any transfer
   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         // Data registers keep their contents, and only control is cleared.
         // A downstream accept in this cycle has already completed.
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (xfer_in) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
                  state_d     = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (xfer_in && xfer_out) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (xfer_in) begin
                  // Downstream stalled: park the new entry behind main
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
                  state_d     = ST_FULL;
               end else if (xfer_out) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (xfer_out) begin
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  state_d     = ST_BUSY;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Saturating count of cycles where downstream was ready but got nothing
   always_comb begin
      bubble_d = bubble_q;
      if (out_ready && !out_valid && (bubble_q != {CNT_W{1'b1}}))
         bubble_d = bubble_q + 1'b1;
   end

   // State and entry registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   // Bubble counter register; only rst_n clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bubble_q <= '0;
      else        bubble_q <= bubble_d;
   end

endmodule
